// File: rtl/riscv_defs.sv
// -----------------------------------------------------------------------------
// riscv_defs
// Shared definitions for the pipeline control blocks.
//   NB_OPERAND     : register-index width (x0..x31)
//   hazard_state_t : state encoding of the hazard-control FSM
// -----------------------------------------------------------------------------
package riscv_defs;

  localparam int NB_OPERAND = 5;

  // STALL2/STALL1 hold the number of stall cycles still owed.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL2   = 2'd1,
    STALL1   = 2'd2,
    MEM_WAIT = 2'd3
  } hazard_state_t;

endpackage

// File: rtl/hazard_stats.sv
// -----------------------------------------------------------------------------
// hazard_stats
// Wrapping statistics counters for the hazard unit. The module only exists
// when HAZARD_STATS_EN is defined, so a build without statistics carries no
// counter flops at all.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_stall_evt   : this cycle is a bubble or freeze cycle
//   i_flush_evt   : this cycle flushes IF/ID
//   o_stall_cnt   : stall/freeze cycle count, modulo 2^NB_CNT
//   o_flush_cnt   : flush cycle count, modulo 2^NB_CNT
// -----------------------------------------------------------------------------
`ifdef HAZARD_STATS_EN
module hazard_stats #(
  parameter int NB_CNT = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall_evt,
  input  logic              i_flush_evt,
  output logic [NB_CNT-1:0] o_stall_cnt,
  output logic [NB_CNT-1:0] o_flush_cnt
);

  logic [NB_CNT-1:0] r_stall_cnt;
  logic [NB_CNT-1:0] r_flush_cnt;

  // Event counters; natural overflow gives the modulo wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt <= {NB_CNT{1'b0}};
      r_flush_cnt <= {NB_CNT{1'b0}};
    end else begin
      if (i_stall_evt) begin
        r_stall_cnt <= r_stall_cnt + NB_CNT'(1);
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
      if (i_flush_evt) begin
        r_flush_cnt <= r_flush_cnt + NB_CNT'(1);
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule
`endif

// File: rtl/hazard_control.sv
// -----------------------------------------------------------------------------
// hazard_control
// Stall / flush / freeze control for a 5-stage RISC-V pipeline with branches
// resolved in ID and a data memory that may take extra cycles.
// Optional feature: define HAZARD_STATS_EN to add the stall/flush counters
// (sub-module hazard_stats); otherwise the counter outputs are tied to 0.
// Ports:
//   i_clk, i_rst                       : clock, synchronous active-high reset
//   i_if_id_rs1/rs2, i_if_id_use_rs1/2 : sources of the ID instruction
//   i_if_id_is_branch, i_branch_taken  : branch/jalr in ID and its outcome
//   i_id_ex_mem_read, i_id_ex_rd       : load in EX and its destination
//   i_ex_mem_mem_read, i_ex_mem_rd     : load in MEM and its destination
//   i_dmem_ready                       : data memory completes this cycle
//   o_pc_write, o_if_id_write          : PC and IF/ID write enables
//   o_id_ex_bubble                     : insert a NOP into ID/EX
//   o_if_id_flush                      : clear IF/ID (taken redirect)
//   o_pipe_freeze                      : hold every pipeline register
//   o_stall_cnt, o_flush_cnt           : statistics counters
// The control outputs are decoded from the state and this cycle's inputs:
// a hazard has to stop the pipeline in the same cycle it is seen.
// -----------------------------------------------------------------------------
module hazard_control #(
  parameter int NB_OPERAND = riscv_defs::NB_OPERAND,
  parameter int NB_CNT     = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NB_OPERAND-1:0] i_if_id_rs1,
  input  logic [NB_OPERAND-1:0] i_if_id_rs2,
  input  logic                  i_if_id_use_rs1,
  input  logic                  i_if_id_use_rs2,
  input  logic                  i_if_id_is_branch,
  input  logic                  i_branch_taken,
  input  logic                  i_id_ex_mem_read,
  input  logic                  i_ex_mem_mem_read,
  input  logic [NB_OPERAND-1:0] i_id_ex_rd,
  input  logic [NB_OPERAND-1:0] i_ex_mem_rd,
  input  logic                  i_dmem_ready,
  output logic                  o_pc_write,
  output logic                  o_if_id_write,
  output logic                  o_id_ex_bubble,
  output logic                  o_if_id_flush,
  output logic                  o_pipe_freeze,
  output logic [NB_CNT-1:0]     o_stall_cnt,
  output logic [NB_CNT-1:0]     o_flush_cnt
);

  import riscv_defs::*;

  hazard_state_t r_state;
  hazard_state_t r_resume;     // stall depth to pick up after MEM_WAIT
  hazard_state_t w_eff_state;  // state whose rules apply this cycle
  hazard_state_t w_depth;      // stall depth owed if a freeze interrupts now
  hazard_state_t w_state_nxt;
  hazard_state_t w_resume_nxt;

  logic w_hz_ex;
  logic w_hz_mem;
  logic w_freeze;
  logic w_stall;
  logic w_flush;

  // A producer only matters if it writes a real register that ID reads.
  function automatic logic f_match(
    input logic [NB_OPERAND-1:0] rd,
    input logic [NB_OPERAND-1:0] rs1,
    input logic [NB_OPERAND-1:0] rs2,
    input logic                  use1,
    input logic                  use2
  );
    f_match = (rd != {NB_OPERAND{1'b0}}) &&
              ((use1 && (rd == rs1)) || (use2 && (rd == rs2)));
  endfunction

  // Hazard terms and the stall depth to remember on a freeze.
  always_comb begin
    w_hz_ex  = i_id_ex_mem_read &&
               f_match(i_id_ex_rd, i_if_id_rs1, i_if_id_rs2,
                       i_if_id_use_rs1, i_if_id_use_rs2);
    w_hz_mem = i_if_id_is_branch && i_ex_mem_mem_read &&
               f_match(i_ex_mem_rd, i_if_id_rs1, i_if_id_rs2,
                       i_if_id_use_rs1, i_if_id_use_rs2);
    if (r_state == MEM_WAIT) begin
      w_eff_state = r_resume;
    end else begin
      w_eff_state = r_state;
    end
    // A non-branch load-use in RUN is simply re-detected after the freeze.
    case (r_state)
      STALL2:  w_depth = STALL2;
      STALL1:  w_depth = STALL1;
      RUN: begin
        if (i_if_id_is_branch && w_hz_ex) begin
          w_depth = STALL2;
        end else if (w_hz_mem) begin
          w_depth = STALL1;
        end else begin
          w_depth = RUN;
        end
      end
      default: w_depth = RUN;
    endcase
  end

  // Next-state and action decode; freeze outranks stall, stall outranks flush.
  // On the cycle memory becomes ready in MEM_WAIT the remembered state acts.
  always_comb begin
    w_freeze     = 1'b0;
    w_stall      = 1'b0;
    w_flush      = 1'b0;
    w_state_nxt  = r_state;
    w_resume_nxt = r_resume;
    if ((r_state == MEM_WAIT) && !i_dmem_ready) begin
      w_freeze    = 1'b1;
      w_state_nxt = MEM_WAIT;
    end else if ((r_state != MEM_WAIT) && i_ex_mem_mem_read && !i_dmem_ready) begin
      w_freeze     = 1'b1;
      w_state_nxt  = MEM_WAIT;
      w_resume_nxt = w_depth;
    end else begin
      case (w_eff_state)
        RUN: begin
          if (w_hz_ex && i_if_id_is_branch) begin
            w_stall     = 1'b1;
            w_state_nxt = STALL1;
          end else if (w_hz_ex || w_hz_mem) begin
            w_stall     = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_flush     = i_if_id_is_branch && i_branch_taken;
            w_state_nxt = RUN;
          end
        end
        STALL2: begin
          w_stall     = 1'b1;
          w_state_nxt = STALL1;
        end
        STALL1: begin
          w_stall     = 1'b1;
          w_state_nxt = RUN;
        end
        default: begin
          w_state_nxt = RUN;
        end
      endcase
    end
  end

  // State and resume-depth registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= RUN;
      r_resume <= RUN;
    end else begin
      r_state  <= w_state_nxt;
      r_resume <= w_resume_nxt;
    end
  end

  // Reset forces the free-running output pattern in the same cycle.
  always_comb begin
    if (i_rst) begin
      o_pc_write     = 1'b1;
      o_if_id_write  = 1'b1;
      o_id_ex_bubble = 1'b0;
      o_if_id_flush  = 1'b0;
      o_pipe_freeze  = 1'b0;
    end else begin
      o_pc_write     = !(w_freeze || w_stall);
      o_if_id_write  = !(w_freeze || w_stall);
      o_id_ex_bubble = w_stall;
      o_if_id_flush  = w_flush;
      o_pipe_freeze  = w_freeze;
    end
  end

`ifdef HAZARD_STATS_EN
  hazard_stats #(
    .NB_CNT (NB_CNT)
  ) u_hazard_stats (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_stall_evt (o_id_ex_bubble | o_pipe_freeze),
    .i_flush_evt (o_if_id_flush),
    .o_stall_cnt (o_stall_cnt),
    .o_flush_cnt (o_flush_cnt)
  );
`else
  assign o_stall_cnt = {NB_CNT{1'b0}};
  assign o_flush_cnt = {NB_CNT{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_control.sv
// -----------------------------------------------------------------------------
// tb_hazard_control
// Directed-vector bench for hazard_control. Counters are built 3 bits wide so
// the wrap is exercised; expected counter values follow from the expected
// outputs of each vector (and are 0 when HAZARD_STATS_EN is not defined).
// -----------------------------------------------------------------------------
module tb_hazard_control;

  localparam int NBO = 5;
  localparam int NBC = 3;

  // Expected {pc_write, if_id_write, bubble, flush, freeze}
  localparam logic [4:0] NORM = 5'b11000;
  localparam logic [4:0] STL  = 5'b00100;
  localparam logic [4:0] FLS  = 5'b11010;
  localparam logic [4:0] FRZ  = 5'b00001;

  logic           clk = 1'b0;
  logic           i_rst = 1'b1;
  logic [NBO-1:0] i_if_id_rs1 = '0;
  logic [NBO-1:0] i_if_id_rs2 = '0;
  logic           i_if_id_use_rs1 = 1'b0;
  logic           i_if_id_use_rs2 = 1'b0;
  logic           i_if_id_is_branch = 1'b0;
  logic           i_branch_taken = 1'b0;
  logic           i_id_ex_mem_read = 1'b0;
  logic           i_ex_mem_mem_read = 1'b0;
  logic [NBO-1:0] i_id_ex_rd = '0;
  logic [NBO-1:0] i_ex_mem_rd = '0;
  logic           i_dmem_ready = 1'b1;
  logic           o_pc_write;
  logic           o_if_id_write;
  logic           o_id_ex_bubble;
  logic           o_if_id_flush;
  logic           o_pipe_freeze;
  logic [NBC-1:0] o_stall_cnt;
  logic [NBC-1:0] o_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [NBC-1:0] m_stall = '0;
  logic [NBC-1:0] m_flush = '0;
  logic           cnt_valid = 1'b0;

  hazard_control #(
    .NB_OPERAND (NBO),
    .NB_CNT     (NBC)
  ) dut (
    .i_clk             (clk),
    .i_rst             (i_rst),
    .i_if_id_rs1       (i_if_id_rs1),
    .i_if_id_rs2       (i_if_id_rs2),
    .i_if_id_use_rs1   (i_if_id_use_rs1),
    .i_if_id_use_rs2   (i_if_id_use_rs2),
    .i_if_id_is_branch (i_if_id_is_branch),
    .i_branch_taken    (i_branch_taken),
    .i_id_ex_mem_read  (i_id_ex_mem_read),
    .i_ex_mem_mem_read (i_ex_mem_mem_read),
    .i_id_ex_rd        (i_id_ex_rd),
    .i_ex_mem_rd       (i_ex_mem_rd),
    .i_dmem_ready      (i_dmem_ready),
    .o_pc_write        (o_pc_write),
    .o_if_id_write     (o_if_id_write),
    .o_id_ex_bubble    (o_id_ex_bubble),
    .o_if_id_flush     (o_if_id_flush),
    .o_pipe_freeze     (o_pipe_freeze),
    .o_stall_cnt       (o_stall_cnt),
    .o_flush_cnt       (o_flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, then check outputs and
  // the counter values accumulated over the earlier cycles.
  task automatic step(input string tag, input logic rst,
                      input logic [NBO-1:0] rs1, input logic u1,
                      input logic [NBO-1:0] rs2, input logic u2,
                      input logic br, input logic tk,
                      input logic exmr, input logic [NBO-1:0] exrd,
                      input logic mmr, input logic [NBO-1:0] mrd,
                      input logic rdy, input logic [4:0] exp);
    @(negedge clk);
    i_rst = rst;
    i_if_id_rs1 = rs1;  i_if_id_use_rs1 = u1;
    i_if_id_rs2 = rs2;  i_if_id_use_rs2 = u2;
    i_if_id_is_branch = br;  i_branch_taken = tk;
    i_id_ex_mem_read = exmr; i_id_ex_rd = exrd;
    i_ex_mem_mem_read = mmr; i_ex_mem_rd = mrd;
    i_dmem_ready = rdy;
    #1;
    chk_eq({tag, "_out"},
           {27'd0, o_pc_write, o_if_id_write, o_id_ex_bubble, o_if_id_flush, o_pipe_freeze},
           {27'd0, exp});
    if (cnt_valid) begin
      chk_eq({tag, "_stall_cnt"}, {29'd0, o_stall_cnt}, {29'd0, m_stall});
      chk_eq({tag, "_flush_cnt"}, {29'd0, o_flush_cnt}, {29'd0, m_flush});
    end
    if (rst) begin
      m_stall = '0;
      m_flush = '0;
      cnt_valid = 1'b1;
    end else begin
`ifdef HAZARD_STATS_EN
      if (exp[2] || exp[0]) m_stall = m_stall + 3'd1;
      if (exp[1]) m_flush = m_flush + 3'd1;
`endif
    end
  endtask

  initial begin
    //        tag            rst rs1 u1 rs2 u2 br tk exmr exrd mmr mrd rdy exp
    step("rst_hz",        1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, NORM);
    step("rst_frz",       1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0, NORM);
    step("idle",          1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, NORM);
    // lw x5 in EX, add x5 in ID
    step("lu_bubble",     1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, STL);
    step("lu_after",      1'b0, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b1, NORM);
    // lw x7 in EX, beq x7,x0 taken: two stalls, then flush
    step("br_ex_1",       1'b0, 5'd7, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, STL);
    step("br_ex_2",       1'b0, 5'd7, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, STL);
    step("br_ex_flush",   1'b0, 5'd7, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, FLS);
    // lw x7 in MEM, beq x7: one stall
    step("br_mem",        1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd7, 1'b1, STL);
    step("br_mem_after",  1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, NORM);
    // ALU producers never stall
    step("alu_ex",        1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd7, 1'b0, 5'd0, 1'b1, FLS);
    step("alu_mem",       1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, NORM);
    // x0 and unused sources
    step("x0_load",       1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, NORM);
    step("x0_branch",     1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, FLS);
    step("unused_rs",     1'b0, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, NORM);
    step("rs2_match",     1'b0, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b1, STL);
    // STALL1 stalls regardless of its inputs
    step("s1_enter",      1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, STL);
    step("s1_only",       1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, STL);
    step("s1_done",       1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, NORM);
    // Memory wait of 3 cycles during STALL1: 3 freezes then 1 stall
    step("frz_enter",     1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, STL);
    step("frz_1",         1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, FRZ);
    step("frz_2",         1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, FRZ);
    step("frz_3",         1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, FRZ);
    step("frz_resume",    1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1, STL);
    step("frz_after",     1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, FLS);
    // Freeze interrupts a two-deep branch stall: resume via STALL2
    step("s2_frz1",       1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 5'd8, 1'b0, FRZ);
    step("s2_frz2",       1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b1, 5'd8, 1'b0, FRZ);
    step("s2_res",        1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 1'b1, STL);
    step("s2_s1",         1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, STL);
    step("s2_done",       1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, FLS);
    // Reset in MEM_WAIT abandons the owed stall
    step("mw_enter",      1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b1, STL);
    step("mw_frz",        1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, FRZ);
    step("mw_rst",        1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0, NORM);
    step("mw_post",       1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, NORM);
    step("final_idle",    1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, NORM);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
